nf10_axil_reg_master: RTL and testbench

AXI4-Lite master (initiator) that turns single register commands into AXI4-Lite write or read transactions. It drives the S_AXI register port of stream generator/checker peripherals in the loopback test design. A test sequencer or host bridge uses it to program generator/checker registers and read back their counters. It handles one transaction at a time, enforces a response timeout, and keeps status counters.

---
 rtl/nf10_axil_reg_master_if.sv | 39 +++
 rtl/nf10_axil_reg_master.sv | 276 +++++++++++++++++++++++++++
 tb/tb_nf10_axil_reg_master.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nf10_axil_reg_master_if.sv
// AXI4-Lite register-port bundle between the register master and a peripheral's S_AXI port.
interface nf10_axil_reg_master_if #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32
);
    logic [C_ADDR_WIDTH-1:0]   AWADDR;
    logic                      AWVALID;
    logic                      AWREADY;
    logic [C_DATA_WIDTH-1:0]   WDATA;
    logic [C_DATA_WIDTH/8-1:0] WSTRB;
    logic                      WVALID;
    logic                      WREADY;
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;
    logic [C_ADDR_WIDTH-1:0]   ARADDR;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [C_DATA_WIDTH-1:0]   RDATA;
    logic [1:0]                RRESP;
    logic                      RVALID;
    logic                      RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/nf10_axil_reg_master.sv
// Single-outstanding AXI4-Lite register master: one command in, one AXI transaction out,
// with a response timeout and saturating completion/error counters.
module nf10_axil_reg_master #(
    parameter int C_TIMEOUT_CYCLES = 1024,
    parameter int C_ADDR_WIDTH     = 32,
    parameter int C_DATA_WIDTH     = 32
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [15:0]               wr_count,
    output logic [15:0]               rd_count,
    output logic [15:0]               err_count,
    nf10_axil_reg_master_if.master    m_axi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RSP
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    state_t                    state_q, state_d;
    logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [C_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                      rnw_q, rnw_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic                      bready_q, bready_d;
    logic                      rready_q, rready_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [C_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic [15:0]               tmo_q, tmo_d;
    logic [15:0]               wr_cnt_q, wr_cnt_d;
    logic [15:0]               rd_cnt_q, rd_cnt_d;
    logic [15:0]               err_cnt_q, err_cnt_d;

    logic cmd_hs, rsp_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic expired, abort, aw_left, w_left;

    assign cmd_hs  = cmd_ready_q & cmd_valid;
    assign rsp_hs  = rsp_valid_q & rsp_ready;
    assign aw_hs   = awvalid_q & m_axi.AWREADY;
    assign w_hs    = wvalid_q & m_axi.WREADY;
    assign b_hs    = bready_q & m_axi.BVALID;
    assign ar_hs   = arvalid_q & m_axi.ARREADY;
    assign r_hs    = rready_q & m_axi.RVALID;
    assign expired = (tmo_q == TMO_LAST);
    assign aw_left = awvalid_q & ~aw_hs;
    assign w_left  = wvalid_q & ~w_hs;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rnw_d         = rnw_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        tmo_d         = tmo_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        err_cnt_d     = err_cnt_q;
        abort         = 1'b0;

        if (state_q inside {S_WR_ADDR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA}) begin
            tmo_d = tmo_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                // READYs stay high here so late B/R beats from an aborted transaction drain silently.
                cmd_ready_d = 1'b1;
                bready_d    = 1'b1;
                rready_d    = 1'b1;
                if (cmd_hs) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    rnw_d       = cmd_rnw;
                    tmo_d       = '0;
                    cmd_ready_d = 1'b0;
                    bready_d    = 1'b0;
                    rready_d    = 1'b0;
                    if (cmd_rnw) begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end else begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_ADDR_DATA;
                    end
                end
            end
            S_WR_ADDR_DATA: begin
                awvalid_d = aw_left;
                wvalid_d  = w_left;
                if (!aw_left && !w_left) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axi.BRESP;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RSP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            S_RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (r_hs) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = m_axi.RRESP;
                    rsp_rdata_d   = m_axi.RDATA;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RSP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_hs) begin
                    rsp_valid_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = '0;
                    rsp_timeout_d = 1'b0;
                    cmd_ready_d   = 1'b1;
                    bready_d      = 1'b1;
                    rready_d      = 1'b1;
                    state_d       = S_IDLE;
                    if (rsp_resp_q == RESP_OKAY && !rsp_timeout_q) begin
                        if (rnw_q) begin
                            rd_cnt_d = sat_inc(rd_cnt_q);
                        end else begin
                            wr_cnt_d = sat_inc(wr_cnt_q);
                        end
                    end else begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort withdraws any pending VALID without waiting for its handshake.
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = RESP_SLVERR;
            rsp_rdata_d   = '0;
            state_d       = S_RSP;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rnw_q         <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            tmo_q         <= '0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rnw_q         <= rnw_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            tmo_q         <= tmo_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign wr_count      = wr_cnt_q;
    assign rd_count      = rd_cnt_q;
    assign err_count     = err_cnt_q;

    assign m_axi.AWADDR  = addr_q;
    assign m_axi.AWVALID = awvalid_q;
    assign m_axi.WDATA   = wdata_q;
    assign m_axi.WSTRB   = wstrb_q;
    assign m_axi.WVALID  = wvalid_q;
    assign m_axi.BREADY  = bready_q;
    assign m_axi.ARADDR  = addr_q;
    assign m_axi.ARVALID = arvalid_q;
    assign m_axi.RREADY  = rready_q;

endmodule

// File: tb/tb_nf10_axil_reg_master.sv
// Directed bench for nf10_axil_reg_master; the bench plays the AXI4-Lite slave by hand.
module tb_nf10_axil_reg_master;

    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] wr_count, rd_count, err_count;

    int n_assert = 0;
    int n_fail   = 0;
    int aw_hs_n  = 0;
    int w_hs_n   = 0;

    nf10_axil_reg_master_if #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(32)) axi ();

    nf10_axil_reg_master #(
        .C_TIMEOUT_CYCLES(16),
        .C_ADDR_WIDTH(32),
        .C_DATA_WIDTH(32)
    ) dut (
        .aclk(clk),
        .areset(areset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .wr_count(wr_count),
        .rd_count(rd_count),
        .err_count(err_count),
        .m_axi(axi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (axi.AWVALID && axi.AWREADY) aw_hs_n <= aw_hs_n + 1;
        if (axi.WVALID && axi.WREADY)   w_hs_n  <= w_hs_n + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        check("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
    endtask

    task automatic finish_write_okay();
        axi.BVALID = 1'b1;
        axi.BRESP  = 2'b00;
        tick();
        axi.BVALID = 1'b0;
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_resp", 32'(rsp_resp), 32'd0);
        check("wr_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("wr_rsp_rdata", rsp_rdata, 32'd0);
        consume_rsp();
    endtask

    initial begin
        areset      = 1'b1;
        cmd_valid   = 1'b0;
        cmd_rnw     = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        cmd_wstrb   = '0;
        rsp_ready   = 1'b0;
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BRESP   = 2'b00;
        axi.ARREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RRESP   = 2'b00;
        axi.RDATA   = '0;

        // Reset values
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_awvalid", 32'(axi.AWVALID), 32'd0);
        check("rst_wvalid", 32'(axi.WVALID), 32'd0);
        check("rst_arvalid", 32'(axi.ARVALID), 32'd0);
        check("rst_bready", 32'(axi.BREADY), 32'd0);
        check("rst_rready", 32'(axi.RREADY), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_counts", {wr_count, rd_count | err_count}, 32'd0);
        areset = 1'b0;
        tick();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_bready", 32'(axi.BREADY), 32'd1);
        check("idle_rready", 32'(axi.RREADY), 32'd1);

        // Zero-wait write: rsp_valid on the third cycle after the cmd handshake
        axi.AWREADY = 1'b1;
        axi.WREADY  = 1'b1;
        issue(1'b0, 32'h7762_0004, 32'hDEAD_BEEF, 4'hF);
        check("w1_awvalid", 32'(axi.AWVALID), 32'd1);
        check("w1_wvalid", 32'(axi.WVALID), 32'd1);
        check("w1_awaddr", axi.AWADDR, 32'h7762_0004);
        check("w1_wdata", axi.WDATA, 32'hDEAD_BEEF);
        check("w1_wstrb", 32'(axi.WSTRB), 32'hF);
        check("w1_bready_c1", 32'(axi.BREADY), 32'd0);
        check("w1_rsp_valid_c1", 32'(rsp_valid), 32'd0);
        tick();
        check("w1_awvalid_c2", 32'(axi.AWVALID), 32'd0);
        check("w1_wvalid_c2", 32'(axi.WVALID), 32'd0);
        check("w1_bready_c2", 32'(axi.BREADY), 32'd1);
        check("w1_rsp_valid_c2", 32'(rsp_valid), 32'd0);
        check("w1_aw_hs", 32'(aw_hs_n), 32'd1);
        check("w1_w_hs", 32'(w_hs_n), 32'd1);
        axi.BVALID = 1'b1;
        tick();
        axi.BVALID = 1'b0;
        check("w1_rsp_valid_c3", 32'(rsp_valid), 32'd1);
        check("w1_rsp_resp", 32'(rsp_resp), 32'd0);
        check("w1_bready_c3", 32'(axi.BREADY), 32'd0);
        tick();
        check("w1_rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("w1_rsp_hold_resp", 32'(rsp_resp), 32'd0);
        check("w1_wr_count_before", 32'(wr_count), 32'd0);
        consume_rsp();
        check("w1_wr_count", 32'(wr_count), 32'd1);

        // Read: ARVALID held until ARREADY, then 5 wait cycles on R
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        issue(1'b1, 32'h7762_0008, 32'h0, 4'h0);
        check("r1_arvalid_c1", 32'(axi.ARVALID), 32'd1);
        check("r1_araddr", axi.ARADDR, 32'h7762_0008);
        check("r1_rready_c1", 32'(axi.RREADY), 32'd0);
        tick();
        check("r1_arvalid_c2", 32'(axi.ARVALID), 32'd1);
        tick();
        check("r1_arvalid_c3", 32'(axi.ARVALID), 32'd1);
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0;
        check("r1_arvalid_done", 32'(axi.ARVALID), 32'd0);
        check("r1_rready", 32'(axi.RREADY), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("r1_wait_no_rsp", 32'(rsp_valid), 32'd0);
        end
        axi.RVALID = 1'b1;
        axi.RDATA  = 32'h1234_5678;
        axi.RRESP  = 2'b00;
        tick();
        axi.RVALID = 1'b0;
        check("r1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("r1_rdata", rsp_rdata, 32'h1234_5678);
        check("r1_resp", 32'(rsp_resp), 32'd0);
        check("r1_rready_off", 32'(axi.RREADY), 32'd0);
        consume_rsp();
        check("r1_rd_count", 32'(rd_count), 32'd1);
        check("r1_wr_count", 32'(wr_count), 32'd1);

        // Write, AW accepted four cycles before W
        axi.AWREADY = 1'b1;
        issue(1'b0, 32'h7762_0010, 32'h0000_00A5, 4'h1);
        tick();
        check("wa_awvalid", 32'(axi.AWVALID), 32'd0);
        check("wa_wvalid", 32'(axi.WVALID), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("wa_bready_wait", 32'(axi.BREADY), 32'd0);
            tick();
        end
        check("wa_bready_wait_last", 32'(axi.BREADY), 32'd0);
        axi.WREADY = 1'b1;
        tick();
        check("wa_wvalid_done", 32'(axi.WVALID), 32'd0);
        check("wa_bready", 32'(axi.BREADY), 32'd1);
        check("wa_aw_hs", 32'(aw_hs_n), 32'd2);
        check("wa_w_hs", 32'(w_hs_n), 32'd2);
        finish_write_okay();

        // Write, W accepted four cycles before AW
        axi.AWREADY = 1'b0;
        issue(1'b0, 32'h7762_0014, 32'h0000_005A, 4'h2);
        tick();
        check("wb_awvalid", 32'(axi.AWVALID), 32'd1);
        check("wb_wvalid", 32'(axi.WVALID), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("wb_bready_wait", 32'(axi.BREADY), 32'd0);
            tick();
        end
        axi.AWREADY = 1'b1;
        tick();
        check("wb_awvalid_done", 32'(axi.AWVALID), 32'd0);
        check("wb_bready", 32'(axi.BREADY), 32'd1);
        check("wb_aw_hs", 32'(aw_hs_n), 32'd3);
        check("wb_w_hs", 32'(w_hs_n), 32'd3);
        finish_write_okay();

        // Write, AW and W accepted in the same cycle after one wait
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        issue(1'b0, 32'h7762_0018, 32'h0102_0304, 4'hC);
        tick();
        check("wc_awvalid", 32'(axi.AWVALID), 32'd1);
        check("wc_wvalid", 32'(axi.WVALID), 32'd1);
        check("wc_bready_wait", 32'(axi.BREADY), 32'd0);
        axi.AWREADY = 1'b1;
        axi.WREADY  = 1'b1;
        tick();
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        check("wc_both_done", {31'd0, axi.AWVALID | axi.WVALID}, 32'd0);
        check("wc_bready", 32'(axi.BREADY), 32'd1);
        check("wc_aw_hs", 32'(aw_hs_n), 32'd4);
        check("wc_w_hs", 32'(w_hs_n), 32'd4);
        finish_write_okay();
        check("wc_wr_count", 32'(wr_count), 32'd4);

        // Silent slave: abort on the 16th cycle after the handshake
        issue(1'b1, 32'h7762_000C, 32'h0, 4'h0);
        for (int i = 0; i < 15; i++) tick();
        check("to_rsp_valid_c15", 32'(rsp_valid), 32'd0);
        check("to_arvalid_c15", 32'(axi.ARVALID), 32'd1);
        tick();
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_timeout", 32'(rsp_timeout), 32'd1);
        check("to_resp", 32'(rsp_resp), 32'd2);
        check("to_rdata", rsp_rdata, 32'd0);
        check("to_arvalid_drop", 32'(axi.ARVALID), 32'd0);
        consume_rsp();
        check("to_err_count", 32'(err_count), 32'd1);
        check("to_rd_count", 32'(rd_count), 32'd1);
        check("stray_rready", 32'(axi.RREADY), 32'd1);
        axi.RVALID = 1'b1;
        axi.RDATA  = 32'hFFFF_FFFF;
        tick();
        axi.RVALID = 1'b0;
        tick();
        check("stray_no_rsp", 32'(rsp_valid), 32'd0);
        check("stray_counts", {rd_count, err_count}, {16'd1, 16'd1});
        check("stray_wr_count", 32'(wr_count), 32'd4);

        // Read returning SLVERR
        axi.ARREADY = 1'b1;
        issue(1'b1, 32'h7762_0020, 32'h0, 4'h0);
        tick();
        check("se_rready", 32'(axi.RREADY), 32'd1);
        axi.RVALID = 1'b1;
        axi.RRESP  = 2'b10;
        axi.RDATA  = 32'hCAFE_F00D;
        tick();
        axi.RVALID = 1'b0;
        axi.RRESP  = 2'b00;
        check("se_resp", 32'(rsp_resp), 32'd2);
        check("se_timeout", 32'(rsp_timeout), 32'd0);
        check("se_rdata", rsp_rdata, 32'hCAFE_F00D);
        consume_rsp();
        check("se_counts", {rd_count, err_count}, {16'd1, 16'd2});

        // R handshake on the expiry cycle completes normally
        issue(1'b1, 32'h7762_0024, 32'h0, 4'h0);
        tick();
        axi.ARREADY = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("ex_rsp_valid_c15", 32'(rsp_valid), 32'd0);
        axi.RVALID = 1'b1;
        axi.RDATA  = 32'h0BAD_F00D;
        tick();
        axi.RVALID = 1'b0;
        check("ex_rsp_valid", 32'(rsp_valid), 32'd1);
        check("ex_timeout", 32'(rsp_timeout), 32'd0);
        check("ex_resp", 32'(rsp_resp), 32'd0);
        check("ex_rdata", rsp_rdata, 32'h0BAD_F00D);
        consume_rsp();
        check("ex_counts", {rd_count, err_count}, {16'd2, 16'd2});

        // Reset pulsed while waiting for B
        axi.AWREADY = 1'b1;
        axi.WREADY  = 1'b1;
        issue(1'b0, 32'h7762_0028, 32'h5555_AAAA, 4'hF);
        tick();
        check("rr_bready", 32'(axi.BREADY), 32'd1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("rr_valids", {29'd0, axi.AWVALID, axi.WVALID, axi.ARVALID}, 32'd0);
        check("rr_readys", {30'd0, axi.BREADY, axi.RREADY}, 32'd0);
        check("rr_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rr_counts", {wr_count, rd_count | err_count}, 32'd0);
        tick();
        check("rr_cmd_ready_after", 32'(cmd_ready), 32'd1);
        issue(1'b0, 32'h7762_002C, 32'h1111_2222, 4'hF);
        check("rr2_awaddr", axi.AWADDR, 32'h7762_002C);
        tick();
        check("rr2_bready", 32'(axi.BREADY), 32'd1);
        finish_write_okay();
        check("rr2_wr_count", 32'(wr_count), 32'd1);
        check("rr2_other_counts", {rd_count, err_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
